// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;
  localparam int PIPE_REG_W = 5;
  localparam int PIPE_CNT_W = 32;
  typedef logic [PIPE_REG_W-1:0] reg_idx_t;
  typedef enum logic [1:0] {RUN, EX_BUSY, DISCARD} ctrl_state_e;
  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } pipe_ctrl_t;
endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// pipeline_ctrl_load_use_detect: flags a D-stage read of a register a load in E has not yet produced
module pipeline_ctrl_load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             hazard
);
  assign hazard = ex_is_load && ex_rd != '0 &&
                  ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for F/D/E/M/W; PIPE_CTRL_PERF_EN adds perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = PIPE_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_busy,
  input  logic             d_busy,
  input  logic             ex_multi_start,
  input  logic             ex_multi_done,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_redirect,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             fetch_discard
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cyc
  , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
  ctrl_state_e state_q, state_d;
  pipe_ctrl_t  c;
  logic        hazard, ex_hold, ex_start;
  pipeline_ctrl_load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_is_load(ex_is_load),
    .ex_rd(ex_rd),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use1(id_use1),
    .id_use2(id_use2),
    .hazard(hazard)
  );
  assign ex_hold  = state_q == EX_BUSY && !ex_multi_done;
  assign ex_start = state_q == RUN && ex_multi_start && !ex_multi_done;
  // Priority resolve: d_busy freezes all, then multi-cycle hold, redirect, discard wait, load-use, fetch bubble
  always_comb begin
    c = '0;
    state_d = RUN;
    if (d_busy) begin
      c.stall = 4'b1111;
      c.flush = 4'b0001;
      state_d = state_q;
    end else if (ex_hold || ex_start) begin
      c.stall = 4'b1110;
      c.flush = 4'b0010;
      state_d = EX_BUSY;
    end else if (ex_redirect) begin
      c.flush = 4'b1100;
      state_d = (state_q == DISCARD || i_busy) ? DISCARD : RUN;
    end else if (state_q == DISCARD) begin
      c.flush = 4'b1000;
      state_d = i_busy ? DISCARD : RUN;
    end else if (hazard) begin
      c.stall = 4'b1100;
      c.flush = 4'b0100;
    end else if (i_busy) begin
      c.stall = 4'b1000;
      c.flush = 4'b1000;
    end
  end
  assign {stall_f, stall_d, stall_e, stall_m} = reset ? 4'b0 : c.stall;
  assign {flush_d, flush_e, flush_m, flush_w} = reset ? 4'b0 : c.flush;
  assign fetch_discard = !reset && !d_busy && state_q == DISCARD;
  // Sequencer state; reset abandons any pending multi-cycle op or discard
  always_ff @(posedge clk) state_q <= reset ? RUN : state_d;
`ifdef PIPE_CTRL_PERF_EN
  logic redirect_acc;
  assign redirect_acc = !d_busy && !ex_hold && !ex_start && ex_redirect;
  // Perf counters: stalled cycles and accepted redirects, wrapping at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + CNT_W'(|c.stall);
      perf_flush_cnt <= perf_flush_cnt + CNT_W'(redirect_acc);
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;
  localparam logic [8:0] RST = 9'h100, IB = 9'h080, DB = 9'h040, MS = 9'h020, MD = 9'h010;
  localparam logic [8:0] LD = 9'h008, U1 = 9'h004, U2 = 9'h002, RE = 9'h001, IDLE = 9'h000;
  localparam logic [8:0] NONE = 9'b0000_0000_0;
  localparam logic [8:0] LU   = 9'b1100_0100_0;
  localparam logic [8:0] EXB  = 9'b1110_0010_0;
  localparam logic [8:0] DBZ  = 9'b1111_0001_0;
  localparam logic [8:0] RD   = 9'b0000_1100_0;
  localparam logic [8:0] RDD  = 9'b0000_1100_1;
  localparam logic [8:0] DIS  = 9'b0000_1000_1;
  localparam logic [8:0] IBB  = 9'b1000_1000_0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_busy = 1'b0, d_busy = 1'b0, ex_multi_start = 1'b0, ex_multi_done = 1'b0;
  logic ex_is_load = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, ex_redirect = 1'b0;
  logic [4:0] ex_rd = 5'd5, id_rs1 = 5'd5, id_rs2 = 5'd7;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, fetch_discard;
  logic [8:0] obs;
  int checks = 0;
  int errors = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] perf_stall_cyc, perf_flush_cnt;
`endif
  pipeline_ctrl #(
    .REG_W(5)
`ifdef PIPE_CTRL_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy),
    .ex_multi_start(ex_multi_start), .ex_multi_done(ex_multi_done),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_redirect(ex_redirect),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fetch_discard(fetch_discard)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, fetch_discard};
  task automatic step(input string tag, input logic [8:0] f, input logic [8:0] exp);
    @(negedge clk);
    {reset, i_busy, d_busy, ex_multi_start, ex_multi_done, ex_is_load, id_use1, id_use2, ex_redirect} = f;
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step("reset_all_ones", RST | 9'h0FF, NONE);
    step("release", IDLE, NONE);
    chk_val("state_run", int'(dut.state_q), int'(RUN));
    step("lu_rs1", LD | U1, LU);
    step("lu_one_cycle", IDLE, NONE);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    step("lu_rd0", LD | U1, NONE);
    ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    step("lu_rs2", LD | U2, LU);
    step("lu_unused_src", LD | U1, NONE);
    id_rs1 = 5'd5;
    step("lu_over_ibusy", LD | U1 | IB, LU);
    step("mc_start", MS, EXB);
    for (int i = 0; i < 3; i++) step("mc_hold", IDLE, EXB);
    step("mc_done", MD, NONE);
    step("mc_after", IDLE, NONE);
    step("mc_1cycle", MS | MD, NONE);
    step("mc_1cycle_after", IDLE, NONE);
    step("ibusy", IB, IBB);
    step("redir", RE, RD);
    step("redir_after", IDLE, NONE);
    step("redir_over_lu", RE | LD | U1, RD);
    step("rd_disc_enter", RE | IB, RD);
    for (int i = 0; i < 3; i++) step("rd_disc_wait", IB, DIS);
    step("rd_disc_last", IDLE, DIS);
    step("rd_disc_run", IDLE, NONE);
    step("disc2_enter", RE | IB, RD);
    step("disc2_redir", RE, RDD);
    step("disc2_last", IDLE, DIS);
    step("disc2_run", IDLE, NONE);
    step("db_mc_start", MS, EXB);
    step("db_in_exbusy", DB, DBZ);
    step("db_with_redir", DB | RE, DBZ);
    step("db_fall_done_redir", MD | RE, RD);
    step("db_after", IDLE, NONE);
    step("db_run_redir", DB | RE, DBZ);
    step("db_redir_represented", RE, RD);
    step("db_disc_enter", RE | IB, RD);
    step("db_in_discard", DB | IB, DBZ);
    step("db_disc_resume", IB, DIS);
    step("db_disc_last", IDLE, DIS);
    step("db_disc_run", IDLE, NONE);
    step("rst_mc_start", MS, EXB);
    step("rst_mid_exbusy", RST, NONE);
    step("rst_abandon", IDLE, NONE);
    step("rst_disc_enter", RE | IB, RD);
    step("rst_mid_discard", RST | IB, NONE);
    step("rst_disc_abandon", IB, IBB);
`ifdef PIPE_CTRL_PERF_EN
    step("perf_reset", RST, NONE);
    step("perf_release", IDLE, NONE);
    chk_val("perf_stall_zero", int'(perf_stall_cyc), 0);
    chk_val("perf_flush_zero", int'(perf_flush_cnt), 0);
    for (int i = 0; i < 10; i++) step("perf_stall", IB, IBB);
    step("perf_redir1", RE, RD);
    step("perf_redir2", RE, RD);
    step("perf_idle", IDLE, NONE);
    chk_val("perf_stall_10", int'(perf_stall_cyc), 10);
    chk_val("perf_flush_2", int'(perf_flush_cnt), 2);
    for (int i = 0; i < 6; i++) step("perf_stall_more", IB, IBB);
    step("perf_idle2", IDLE, NONE);
    chk_val("perf_stall_wrap", int'(perf_stall_cyc), 0);
    chk_val("perf_flush_hold", int'(perf_flush_cnt), 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
